// File: rtl/nes_pkg.sv
// Shared NES definitions used by the sprite DMA engine and its neighbours.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WAIT,
    WRITE,
    FINISH
  } dma_state_e;

  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam int          OAM_BYTES   = 256;

endpackage

// File: rtl/sprite_dma_engine.sv
// OAM DMA controller: a CPU write to the trigger address stalls the CPU and
// copies LEN bytes from one CPU-space page into sprite OAM, starting at the
// PPU's current OAMADDR and wrapping within OAM.
module sprite_dma_engine
  import nes_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter int                DST_W     = 8,
  parameter int                LEN       = OAM_BYTES,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = OAMDMA_ADDR,
  parameter int                RD_LAT    = 1,
  parameter bit                ALIGN_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  input  logic              cpu_odd,
  input  logic [DST_W-1:0]  oam_base,
  output logic              halt,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rden,
  input  logic [DATA_W-1:0] src_rdata,
  output logic [DST_W-1:0]  dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_wren,
  output logic              busy,
  output logic              done
);

  // Value of the latency counter in the final WAIT cycle; unused when RD_LAT is 1.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  dma_state_e       state;
  dma_state_e       state_next;
  logic [7:0]       page;
  logic [DST_W-1:0] count;
  logic [DST_W-1:0] dst;
  logic [1:0]       lat_cnt;
  logic             trigger;
  logic             last_byte;
  logic [7:0]       src_lo;

  assign trigger   = (state == IDLE) && cpu_wren && (cpu_addr == TRIG_ADDR);
  assign last_byte = (count == DST_W'(LEN - 1));
  assign src_lo    = 8'(count);

  // State register; reset aborts any transfer on the next edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Transfer bookkeeping: page/destination latched at trigger, count and
  // destination advance after each write except the last so the addresses
  // hold their final values once the engine goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      page    <= '0;
      count   <= '0;
      dst     <= '0;
      lat_cnt <= '0;
    end else begin
      if (trigger) begin
        page  <= cpu_wdata[7:0];
        dst   <= oam_base;
        count <= '0;
      end
      if (state == WRITE && !last_byte) begin
        count <= count + 1'b1;
        dst   <= dst + 1'b1;
      end
      if (state == READ)      lat_cnt <= '0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
    end
  end

  // Next-state sequencing: HALT, optional ALIGN, then READ/WAIT/WRITE per byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = HALT;
      HALT:    state_next = (ALIGN_EN && cpu_odd) ? ALIGN : READ;
      ALIGN:   state_next = READ;
      READ:    state_next = (RD_LAT > 1) ? WAIT : WRITE;
      WAIT:    if (lat_cnt == WAIT_LAST) state_next = WRITE;
      WRITE:   state_next = last_byte ? FINISH : READ;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode; the enables are the only qualifiers on the address buses.
  always_comb begin
    halt     = 1'b0;
    busy     = 1'b0;
    src_rden = 1'b0;
    dst_wren = 1'b0;
    done     = 1'b0;
    dst_data = '0;
    src_addr = ADDR_W'({page, src_lo});
    dst_addr = dst;
    case (state)
      HALT, ALIGN, READ, WAIT: begin
        halt = 1'b1;
        busy = 1'b1;
        if (state == READ) src_rden = 1'b1;
      end
      WRITE: begin
        halt     = 1'b1;
        busy     = 1'b1;
        dst_wren = 1'b1;
        dst_data = src_rdata;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_dma_engine.sv
// Directed self-checking bench for sprite_dma_engine: a default instance (A)
// and a short, slow-source instance (B, RD_LAT=3, LEN=4).
module tb_sprite_dma_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpuAddr = '0;
  logic [7:0]  cpuWdata = '0;
  logic        wrenA = 1'b0;
  logic        wrenB = 1'b0;
  logic        cpuOdd = 1'b0;
  logic [7:0]  oamBase = '0;

  logic        haltA, srcRdenA, dstWrenA, busyA, doneA;
  logic [15:0] srcAddrA;
  logic [7:0]  srcRdataA, dstAddrA, dstDataA;
  logic        haltB, srcRdenB, dstWrenB, busyB, doneB;
  logic [15:0] srcAddrB;
  logic [7:0]  srcRdataB, dstAddrB, dstDataB;
  logic [7:0]  pipeB1, pipeB2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_dma_engine dutA (
    .clk(clk), .reset(reset), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_wren(wrenA), .cpu_odd(cpuOdd), .oam_base(oamBase), .halt(haltA),
    .src_addr(srcAddrA), .src_rden(srcRdenA), .src_rdata(srcRdataA),
    .dst_addr(dstAddrA), .dst_data(dstDataA), .dst_wren(dstWrenA),
    .busy(busyA), .done(doneA)
  );

  sprite_dma_engine #(.RD_LAT(3), .LEN(4)) dutB (
    .clk(clk), .reset(reset), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_wren(wrenB), .cpu_odd(cpuOdd), .oam_base(oamBase), .halt(haltB),
    .src_addr(srcAddrB), .src_rden(srcRdenB), .src_rdata(srcRdataB),
    .dst_addr(dstAddrB), .dst_data(dstDataB), .dst_wren(dstWrenB),
    .busy(busyB), .done(doneB)
  );

  // Source memory contents: a fixed scramble of the address.
  function automatic logic [7:0] memModel(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0] + a[7:0] + a[7:0];
    return t ^ a[15:8] ^ 8'h5A;
  endfunction

  // Source memory read pipelines; data only appears for strobed reads.
  always @(posedge clk) begin
    srcRdataA <= srcRdenA ? memModel(srcAddrA) : 8'h00;
    pipeB1    <= srcRdenB ? memModel(srcAddrB) : 8'h00;
    pipeB2    <= pipeB1;
    srcRdataB <= pipeB2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [7:0] page,
                               input logic [7:0] base, input logic odd);
    @(negedge clk);
    cpuAddr  = 16'h4014;
    cpuWdata = page;
    oamBase  = base;
    cpuOdd   = odd;
    if (sel) wrenB = 1'b1;
    else     wrenA = 1'b1;
    @(posedge clk);
    #1;
    wrenA = 1'b0;
    wrenB = 1'b0;
  endtask

  task automatic runTransfer(
    input  bit sel, input logic [7:0] page, input logic [7:0] base,
    input  int lat, input int injectAt,
    output int doneCyc, output int haltCyc, output int doneCnt,
    output int nWrites, output int badData, output int badRead,
    output int badLat, output int overlap,
    output logic [7:0] firstAddr, output logic [7:0] firstData,
    output logic [7:0] lastAddr, output logic [7:0] lastData);
    int cyc, rdIdx, rc;
    int rdCyc[$];
    logic h, b, d, re, we;
    logic [15:0] sa;
    logic [7:0] da, dd, expAddr;
    doneCyc = -1; haltCyc = 0; doneCnt = 0; nWrites = 0; badData = 0;
    badRead = 0; badLat = 0; overlap = 0; cyc = 0; rdIdx = 0;
    firstAddr = '0; firstData = '0; lastAddr = '0; lastData = '0;
    while (cyc < 700 && (doneCyc < 0 || cyc < doneCyc + 4)) begin
      @(negedge clk);
      cyc++;
      if (cyc == injectAt) begin
        cpuAddr = 16'h4014; cpuWdata = 8'h05;
        if (sel) wrenB = 1'b1;
        else     wrenA = 1'b1;
      end else if (cyc == injectAt + 1) begin
        wrenA = 1'b0; wrenB = 1'b0;
      end
      h  = sel ? haltB : haltA;       b  = sel ? busyB : busyA;
      d  = sel ? doneB : doneA;       re = sel ? srcRdenB : srcRdenA;
      we = sel ? dstWrenB : dstWrenA; sa = sel ? srcAddrB : srcAddrA;
      da = sel ? dstAddrB : dstAddrA; dd = sel ? dstDataB : dstDataA;
      if (re) begin
        if (sa !== {page, 8'(rdIdx)}) badRead++;
        rdIdx++;
        rdCyc.push_back(cyc);
      end
      if (we) begin
        expAddr = base + 8'(nWrites);
        if (rdCyc.size() == 0) badLat++;
        else begin
          rc = rdCyc.pop_front();
          if (cyc - rc != lat) badLat++;
        end
        if (da !== expAddr || dd !== memModel({page, 8'(nWrites)})) badData++;
        if (nWrites == 0) begin firstAddr = da; firstData = dd; end
        lastAddr = da; lastData = dd;
        nWrites++;
      end
      if ((re && we) || (h !== b)) overlap++;
      if (h) haltCyc++;
      if (d) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
        if (h) overlap++;
      end
    end
  endtask

  initial begin
    int dc, hc, dn, nw, bd, br, bl, ov, cyc, n;
    logic [7:0] fa, fd, la, ld;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrlA", {haltA, busyA, doneA, srcRdenA, dstWrenA}, 0);
    checkOutput("reset_addrA", {srcAddrA, dstAddrA, dstDataA}, 0);
    checkOutput("reset_ctrlB", {haltB, busyB, doneB, srcRdenB, dstWrenB}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Default transfer, even cycle, page $02 to OAM $00
    applyStimulus(0, 8'h02, 8'h00, 1'b0);
    runTransfer(0, 8'h02, 8'h00, 1, 0, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    checkOutput("even_done_cycle", dc, 514);
    checkOutput("even_halt_cycles", hc, 513);
    checkOutput("even_done_pulses", dn, 1);
    checkOutput("even_writes", nw, 256);
    checkOutput("even_bad_data", bd, 0);
    checkOutput("even_bad_reads", br, 0);
    checkOutput("even_bad_latency", bl, 0);
    checkOutput("even_overlap", ov, 0);
    checkOutput("even_last_addr", la, 8'hFF);

    // Same transfer triggered on an odd cycle
    applyStimulus(0, 8'h02, 8'h00, 1'b1);
    runTransfer(0, 8'h02, 8'h00, 1, 0, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    cpuOdd = 1'b0;
    checkOutput("odd_done_cycle", dc, 515);
    checkOutput("odd_halt_cycles", hc, 514);
    checkOutput("odd_bad_data", bd, 0);
    checkOutput("odd_writes", nw, 256);

    // Destination wrap from base $F0, page $03
    applyStimulus(0, 8'h03, 8'hF0, 1'b0);
    runTransfer(0, 8'h03, 8'hF0, 1, 0, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    checkOutput("wrap_first_addr", fa, 8'hF0);
    checkOutput("wrap_first_data", fd, 8'h59);
    checkOutput("wrap_last_addr", la, 8'hEF);
    checkOutput("wrap_last_data", ld, 8'hA4);
    checkOutput("wrap_bad_data", bd, 0);
    checkOutput("wrap_bad_reads", br, 0);

    // Slow source, four bytes
    applyStimulus(1, 8'h07, 8'h10, 1'b0);
    runTransfer(1, 8'h07, 8'h10, 3, 0, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    checkOutput("lat3_done_cycle", dc, 18);
    checkOutput("lat3_halt_cycles", hc, 17);
    checkOutput("lat3_writes", nw, 4);
    checkOutput("lat3_bad_latency", bl, 0);
    checkOutput("lat3_bad_data", bd, 0);
    checkOutput("lat3_overlap", ov, 0);

    // Second trigger while busy is ignored
    applyStimulus(0, 8'h02, 8'h00, 1'b0);
    runTransfer(0, 8'h02, 8'h00, 1, 10, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    checkOutput("retrig_done_cycle", dc, 514);
    checkOutput("retrig_done_pulses", dn, 1);
    checkOutput("retrig_bad_data", bd, 0);
    checkOutput("retrig_bad_reads", br, 0);

    // Reset during byte 100 aborts the transfer
    applyStimulus(0, 8'h04, 8'h00, 1'b0);
    n = 0; cyc = 0;
    while (n < 100 && cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (dstWrenA) n++;
    end
    checkOutput("abort_reached_byte", n, 100);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ctrl", {haltA, busyA, doneA, srcRdenA, dstWrenA}, 0);
    checkOutput("abort_addr", {srcAddrA, dstAddrA, dstDataA}, 0);
    reset = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (dstWrenA || busyA || doneA) n++;
    end
    checkOutput("abort_quiet", n, 0);

    // Clean transfer after the abort
    applyStimulus(0, 8'h02, 8'h00, 1'b0);
    runTransfer(0, 8'h02, 8'h00, 1, 0, dc, hc, dn, nw, bd, br, bl, ov, fa, fd, la, ld);
    checkOutput("post_abort_done_cycle", dc, 514);
    checkOutput("post_abort_writes", nw, 256);
    checkOutput("post_abort_bad_data", bd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_dma_engine.md
Name: sprite_dma_engine

Overview:
Parametrised OAM DMA controller that replaces the inline $4014 copy logic in the top level. A CPU write to the trigger address stalls the CPU and copies LEN bytes from page {page, 8'h00} of CPU-space memory into sprite OAM. Destination writes start at the PPU's current OAMADDR and wrap. The engine supports configurable source read latency and optional odd-cycle alignment. Sits between the CPU bus (T65), work RAM/PRG read port and OAM port B.

Parameters:
ADDR_W, 16, CPU address width
DATA_W, 8, data byte width
DST_W, 8, OAM address width; destination wraps modulo 2^DST_W
LEN, 256, bytes per transfer (1..2^DST_W)
TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
RD_LAT, 1, source read latency in cycles (1..4)
ALIGN_EN, 1, insert one alignment cycle when the trigger lands on an odd CPU cycle

Ports:
clk  in  1  engine clock, one DMA step per cycle
reset  in  1  synchronous, active-high
cpu_addr  in  ADDR_W  CPU address bus
cpu_wdata  in  DATA_W  CPU write data (source page number)
cpu_wren  in  1  CPU write strobe
cpu_odd  in  1  high on odd CPU cycles (alignment reference)
oam_base  in  DST_W  PPU OAMADDR, sampled at trigger
halt  out  1  high = CPU must not advance (drives cpu_enable low)
src_addr  out  ADDR_W  source read address
src_rden  out  1  source read strobe
src_rdata  in  DATA_W  source data, valid RD_LAT cycles after src_rden
dst_addr  out  DST_W  OAM write address
dst_data  out  DATA_W  OAM write data
dst_wren  out  1  OAM write strobe
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high.
- Reset: all outputs 0. State goes to IDLE and counters clear. Reset mid-transfer aborts immediately, with no further dst_wren.
- Trigger: in IDLE, cpu_wren && cpu_addr==TRIG_ADDR on a rising edge latches page=cpu_wdata[7:0], dst=oam_base, count=0 and moves to HALT. In any non-IDLE state the trigger is ignored; there is no queueing.
- States: IDLE -> HALT -> [ALIGN] -> READ -> WAIT×(RD_LAT-1) -> WRITE -> (READ | FINISH) -> IDLE.
- HALT: 1 cycle. Lets the CPU finish its current write. ALIGN is entered only if ALIGN_EN && cpu_odd sampled in HALT; it lasts 1 cycle.
- READ: src_rden=1, src_addr={page, count[7:0]} zero-extended to ADDR_W.
- WAIT: idle cycles, so data arrives exactly at WRITE.
- WRITE: dst_wren=1, dst_addr=dst, dst_data=src_rdata (no capture register needed because latency is fixed). Then count+1 and dst+1 mod 2^DST_W. Go to FINISH if count==LEN-1, else READ.
- FINISH: 1 cycle, done=1 and halt=0. Next state is IDLE.
- halt=busy=1 from HALT through the last WRITE inclusive; both are 0 in FINISH and IDLE.
- Duration trigger->done = 1 + align + LEN*(1+RD_LAT) + 1 cycles. Defaults: 514 cycles (even) or 515 (odd).
- src_rden and dst_wren are never high in the same cycle.
- The source page is never incremented: a LEN > 256 source wraps within the page.
- Outputs are registered-state decodes (Moore). src_addr and dst_addr hold their last value when idle; the enables are the only qualifiers.

Decomposition:
- Shared package nes_pkg: dma_state_e enum (IDLE, HALT, ALIGN, READ, WAIT, WRITE, FINISH), OAMDMA_ADDR=16'h4014, OAM_BYTES=256.
- No sub-module is needed. A small latency counter sits inline. Top-level instantiates sprite_dma_engine and removes its inline dma logic; cpu_enable = ~halt.

Test Plan:
- Default params, oam_base=0, cpu_odd=0, write 8'h02 to $4014 -> halt high for 513 cycles. Reads cover $0200..$02FF; OAM[i]=RAM[$0200+i]; done pulses at cycle 514.
- Same transfer with cpu_odd=1 at trigger -> exactly one extra ALIGN cycle, done at cycle 515, data identical.
- oam_base=8'hF0, page 8'h03 -> first write dst_addr=F0 with RAM[$0300]; dst wraps FF->00; last write dst_addr=EF with RAM[$03FF].
- RD_LAT=3, LEN=4 -> per byte READ, WAIT, WAIT, WRITE. dst_data equals memory model output 3 cycles after src_rden. Total 1+16+1=18 cycles.
- Second $4014 write while busy -> ignored; page and count unchanged; one done pulse only.
- Reset asserted at byte 100 -> next cycle all outputs 0 and state IDLE. A new trigger afterwards runs a full clean transfer.
